alu_arbiter: RTL

- Master-side SPI controller that shares the single serial ALU among NUM_REQ requesters (decode/execute units).
- Arbitrates round-robin and serializes {op_2, op_1, op_code} LSB-first over mosi, one bit per i_clock.
- Deserializes the DATA_WIDTH result from miso and returns it to the granted requester with a valid/ready handshake.
- Watchdog reports a response timeout as an error.

---
 rtl/alu_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin master that shares one bit-serial ALU among NUM_REQ requesters over an SPI-style link.
// A start bit and the {op2, op1, op} packet go out LSB-first; the result comes back LSB-first after the ALU's start bit.

localparam int REGISTER_SIZE = 8;

typedef enum logic [1:0] {
  ALU_ADD = 2'd0,
  ALU_SUB = 2'd1,
  ALU_AND = 2'd2,
  ALU_OR  = 2'd3
} AluOperation;

module alu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = REGISTER_SIZE,
  parameter int OP_WIDTH   = $bits(AluOperation),
  parameter int TIMEOUT    = 64
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]      i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_op2,
  output logic [NUM_REQ-1:0]               o_resp_valid,
  input  logic [NUM_REQ-1:0]               i_resp_ready,
  output logic [DATA_WIDTH-1:0]            o_resp_data,
  output logic                             o_resp_error,
  output logic                             o_nss,
  output logic                             o_mosi,
  input  logic                             i_miso
);

  localparam int P     = OP_WIDTH + 2 * DATA_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BIT_W = $clog2(P + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W:0]   NREQ_L   = (IDX_W + 1)'(NUM_REQ);
  localparam logic [BIT_W-1:0] TX_LAST  = BIT_W'(P - 1);
  localparam logic [BIT_W-1:0] RX_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TX,
    S_WAIT,
    S_RX,
    S_RESP
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       gnt_q;
  logic [P-1:0]           shreg_q;
  logic [BIT_W-1:0]       bitcnt_q;
  logic [TO_W-1:0]        tocnt_q;
  logic                   nss_q;
  logic                   mosi_q;
  logic [NUM_REQ-1:0]     resp_valid_q;
  logic [DATA_WIDTH-1:0]  resp_data_q;
  logic                   resp_err_q;

  logic                   any_req;
  logic [IDX_W-1:0]       gnt_d;
  logic [P-1:0]           pkt_d;
  logic [NUM_REQ-1:0]     req_ready_d;
  logic [NUM_REQ-1:0]     gnt_oh;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input logic [IDX_W:0]   off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + off;
    if (s >= NREQ_L) s = s - NREQ_L;
    return s[IDX_W-1:0];
  endfunction

  assign any_req = |i_req_valid;

  // Scan from the farthest offset down so the nearest valid index at/after the pointer wins.
  always_comb begin
    gnt_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[rr_idx(ptr_q, (IDX_W + 1)'(i))]) gnt_d = rr_idx(ptr_q, (IDX_W + 1)'(i));
    end
  end

  always_comb begin
    pkt_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_d == IDX_W'(i)) begin
        pkt_d = {i_req_op2[i*DATA_WIDTH +: DATA_WIDTH],
                 i_req_op1[i*DATA_WIDTH +: DATA_WIDTH],
                 i_req_op[i*OP_WIDTH +: OP_WIDTH]};
      end
    end
  end

  always_comb begin
    req_ready_d = '0;
    if (state_q == S_IDLE && any_req) req_ready_d[gnt_d] = 1'b1;
  end

  assign gnt_oh = NUM_REQ'(1) << gnt_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      tocnt_q      <= '0;
      nss_q        <= 1'b1;
      mosi_q       <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          nss_q  <= 1'b1;
          mosi_q <= 1'b0;
          if (any_req) begin
            shreg_q <= pkt_d;
            gnt_q   <= gnt_d;
            ptr_q   <= rr_idx(gnt_d, (IDX_W + 1)'(1));
            nss_q   <= 1'b0;
            mosi_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          mosi_q   <= shreg_q[0];
          shreg_q  <= shreg_q >> 1;
          bitcnt_q <= '0;
          state_q  <= S_TX;
        end
        S_TX: begin
          if (bitcnt_q == TX_LAST) begin
            mosi_q  <= 1'b0;
            tocnt_q <= '0;
            state_q <= S_WAIT;
          end else begin
            mosi_q   <= shreg_q[0];
            shreg_q  <= shreg_q >> 1;
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_miso) begin
            tocnt_q  <= '0;
            bitcnt_q <= '0;
            state_q  <= S_RX;
          end else if (tocnt_q == TO_LAST) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= gnt_oh;
            nss_q        <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            tocnt_q <= tocnt_q + 1'b1;
          end
        end
        S_RX: begin
          // Result shifts in from the top so the first bit received lands in bit 0.
          resp_data_q <= {i_miso, resp_data_q[DATA_WIDTH-1:1]};
          if (bitcnt_q == RX_LAST) begin
            resp_err_q   <= 1'b0;
            resp_valid_q <= gnt_oh;
            nss_q        <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (i_resp_ready[gnt_q]) begin
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          nss_q   <= 1'b1;
          mosi_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = req_ready_d;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_resp_error = resp_err_q;
  assign o_nss        = nss_q;
  assign o_mosi       = mosi_q;

endmodule
